// File: rtl/chip_data_merger_pkg.sv
// Shared constants and helpers for the chip data merger.
package chip_data_merger_pkg;

  localparam int unsigned TAG_W_DEF      = 4;
  localparam int unsigned TAG_MARK_POS   = TAG_W_DEF - 1;
  localparam int unsigned MARK_CNT_W     = 16;
  localparam int unsigned LOST_CNT_W_DEF = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Tag = {marker, channel index}; the marker sits in the tag MSB.
  function automatic int unsigned tag_compose(input logic marker, input int unsigned idx,
                                              input int unsigned tag_w);
    return (int'(marker) << (tag_w - 1)) | idx;
  endfunction

endpackage

// File: rtl/chip_data_merger_ch_fifo.sv
// Per-channel buffer with full/empty tracking, drop counter and optional
// overflow marker insertion (CHIP_MERGER_OVF_MARKER_EN).
module merger_ch_fifo
  import chip_data_merger_pkg::*;
#(
  parameter int unsigned DATA_W     = 28,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOST_CNT_W = LOST_CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  wr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  pop_i,
  output logic                  ready_o,
  output logic                  empty_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rmark_o,
  output logic [LOST_CNT_W-1:0] lost_cnt_o
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);
`ifdef CHIP_MERGER_OVF_MARKER_EN
  localparam int unsigned EW = DATA_W + 1;
`else
  localparam int unsigned EW = DATA_W;
`endif
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         wentry, rentry;
  logic                  full, full_d;
  logic                  push, do_pop, drop;
  logic                  ready_q, ready_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rentry  = mem_q[rd_ptr_q[AW-1:0]];
  assign rdata_o = rentry[DATA_W-1:0];

`ifdef CHIP_MERGER_OVF_MARKER_EN
  logic                  pend_q, pend_d, mk_push, push_data;
  logic [MARK_CNT_W-1:0] mk_cnt_q, mk_cnt_d;

  // A pending marker takes the buffer slot ahead of any new data.
  assign mk_push   = en_i && pend_q && !full;
  assign push_data = en_i && wr_i && !full && !pend_q;
  assign drop      = en_i && wr_i && (full || pend_q);
  assign push      = push_data || mk_push;
  assign wentry    = mk_push ? {1'b1, DATA_W'(mk_cnt_q)} : {1'b0, wdata_i};
  assign rmark_o   = rentry[DATA_W];

  always_comb begin
    pend_d   = pend_q;
    mk_cnt_d = mk_cnt_q;
    if (!en_i) begin
      pend_d   = 1'b0;
      mk_cnt_d = '0;
    end else if (mk_push) begin
      pend_d   = drop;
      mk_cnt_d = drop ? MARK_CNT_W'(1) : '0;
    end else if (drop) begin
      pend_d = 1'b1;
      if (mk_cnt_q != '1) mk_cnt_d = mk_cnt_q + MARK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= 1'b0;
      mk_cnt_q <= '0;
    end else if (clear_i) begin
      pend_q   <= 1'b0;
      mk_cnt_q <= '0;
    end else begin
      pend_q   <= pend_d;
      mk_cnt_q <= mk_cnt_d;
    end
  end
`else
  assign drop    = en_i && wr_i && full;
  assign push    = en_i && wr_i && !full;
  assign wentry  = wdata_i;
  assign rmark_o = 1'b0;
`endif

  assign do_pop = en_i && pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = '0;
    rd_ptr_d = '0;
    if (en_i) begin
      wr_ptr_d = push   ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
`ifdef CHIP_MERGER_OVF_MARKER_EN
    ready_d = en_i && !full_d && !pend_d;
`else
    ready_d = en_i && !full_d;
`endif
    lost_d = lost_q;
    if (drop && (lost_q != '1)) lost_d = lost_q + LOST_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      lost_q   <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      lost_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wentry;
  end

  assign ready_o    = ready_q;
  assign lost_cnt_o = lost_q;

endmodule

// File: rtl/chip_data_merger.sv
// N-channel round-robin merger into one tagged output register.
// Optional in-stream overflow markers: define CHIP_MERGER_OVF_MARKER_EN.
module chip_data_merger
  import chip_data_merger_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_W     = 28,
  parameter int unsigned TAG_W      = TAG_W_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOST_CNT_W = LOST_CNT_W_DEF
) (
  input  logic                         CLK,
  input  logic                         RESETB,
  input  logic                         CLEAR,
  input  logic [N_CH-1:0]              CH_EN,
  input  logic [N_CH-1:0]              CH_WRITE,
  input  logic [N_CH*DATA_W-1:0]       CH_DATA,
  output logic [N_CH-1:0]              CH_READY,
  output logic                         OUT_VALID,
  input  logic                         OUT_READ,
  output logic [TAG_W+DATA_W-1:0]      OUT_DATA,
  output logic [N_CH*LOST_CNT_W-1:0]   LOST_CNT
);

  localparam int unsigned IW = (N_CH > 1) ? clog2(N_CH) : 1;

  logic [N_CH-1:0]         empty, rmark, req, pop;
  logic [DATA_W-1:0]       rdata [N_CH];
  logic [IW-1:0]           rr_q, grant_idx, rr_next;
  logic                    grant_found, load;
  logic                    out_valid_q;
  logic [TAG_W+DATA_W-1:0] out_data_q, out_word;
  logic [TAG_W-1:0]        tag;
  int unsigned             cand;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    merger_ch_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .LOST_CNT_W (LOST_CNT_W)
    ) u_fifo (
      .clk_i      (CLK),
      .rst_ni     (RESETB),
      .clear_i    (CLEAR),
      .en_i       (CH_EN[g]),
      .wr_i       (CH_WRITE[g]),
      .wdata_i    (CH_DATA[g*DATA_W +: DATA_W]),
      .pop_i      (pop[g]),
      .ready_o    (CH_READY[g]),
      .empty_o    (empty[g]),
      .rdata_o    (rdata[g]),
      .rmark_o    (rmark[g]),
      .lost_cnt_o (LOST_CNT[g*LOST_CNT_W +: LOST_CNT_W])
    );
  end

  // rr_q holds the next search start, i.e. last_grant+1 mod N_CH.
  always_comb begin
    req         = CH_EN & ~empty;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = (32'(rr_q) + k) % N_CH;
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
    load    = (!out_valid_q || OUT_READ) && grant_found;
    rr_next = (grant_idx == IW'(N_CH - 1)) ? '0 : grant_idx + IW'(1);
    pop     = '0;
    if (load) pop[grant_idx] = 1'b1;
    tag      = TAG_W'(tag_compose(rmark[grant_idx], 32'(grant_idx), TAG_W));
    out_word = {tag, rdata[grant_idx]};
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_q        <= '0;
    end else if (CLEAR) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_q        <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_word;
      rr_q        <= rr_next;
    end else if (OUT_READ) begin
      out_valid_q <= 1'b0;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_chip_data_merger.sv
// Scoreboard bench for chip_data_merger (default parameters).
module tb_chip_data_merger;

  logic        CLK = 1'b0;
  logic        RESETB, CLEAR, OUT_READ, OUT_VALID;
  logic [3:0]  CH_EN, CH_WRITE, CH_READY;
  logic [111:0] CH_DATA;
  logic [31:0] OUT_DATA;
  logic [31:0] LOST_CNT;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;
  logic [31:0] held_data;
  logic        stall_prev = 1'b0;

  always #5 CLK = ~CLK;

  chip_data_merger #(
    .N_CH(4), .DATA_W(28), .TAG_W(4), .FIFO_DEPTH(16), .LOST_CNT_W(8)
  ) dut (
    .CLK(CLK), .RESETB(RESETB), .CLEAR(CLEAR), .CH_EN(CH_EN), .CH_WRITE(CH_WRITE),
    .CH_DATA(CH_DATA), .CH_READY(CH_READY), .OUT_VALID(OUT_VALID), .OUT_READ(OUT_READ),
    .OUT_DATA(OUT_DATA), .LOST_CNT(LOST_CNT)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr1(input int unsigned ch, input logic [27:0] d);
    CH_WRITE = '0;
    CH_WRITE[ch] = 1'b1;
    CH_DATA[ch*28 +: 28] = d;
    tick();
    CH_WRITE = '0;
  endtask

  task automatic drain();
    OUT_READ = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0 && !OUT_VALID) break;
      tick();
    end
    chk("drain_done", 64'(sb.size()), 0);
    chk("drain_idle", 64'(OUT_VALID), 0);
  endtask

  // Output monitor: scoreboard pop on transfer, hold check while stalled.
  always @(negedge CLK) begin
    if (RESETB) begin
      if (stall_prev) chk("hold_stable", {OUT_VALID, OUT_DATA}, {1'b1, held_data});
      if (OUT_VALID && OUT_READ) begin
        chk("sb_has_entry", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("out_word", OUT_DATA, exp_w);
        end
      end
      stall_prev = OUT_VALID && !OUT_READ && !CLEAR;
      held_data  = OUT_DATA;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    RESETB = 1'b0; CLEAR = 1'b0; CH_EN = '1; CH_WRITE = '0; CH_DATA = '0; OUT_READ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", 64'(OUT_VALID), 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_ready", CH_READY, 0);
    chk("rst_lost", LOST_CNT, 0);
    RESETB = 1'b1;
    tick();
    chk("ready_after_rst", CH_READY, 4'hF);

    // Latency: write in cycle 0, valid in cycle 2.
    sb.push_back(32'h20000ABC);
    wr1(2, 28'h0000ABC);
    chk("lat_c1_valid", 64'(OUT_VALID), 0);
    tick();
    chk("lat_c2_valid", 64'(OUT_VALID), 1);
    chk("lat_c2_data", OUT_DATA, 32'h20000ABC);
    chk("lat_lost", LOST_CNT, 0);
    drain();

    // Simultaneous burst after CLEAR: grants 0,1,2,3 back-to-back.
    CLEAR = 1'b1; tick(); CLEAR = 1'b0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      CH_DATA[ch*28 +: 28] = 28'h00A0000 + 28'(ch);
      sb.push_back({4'(ch), 28'h00A0000 + 28'(ch)});
    end
    CH_WRITE = '1; tick(); CH_WRITE = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("burst_valid", 64'(OUT_VALID), 1);
      tick();
    end
    chk("burst_end", 64'(OUT_VALID), 0);
    // Two words each on ch1/ch2: round robin must alternate.
    CH_WRITE = 4'b0110;
    CH_DATA[28 +: 28] = 28'h0B1000A; CH_DATA[56 +: 28] = 28'h0B2000A; tick();
    CH_DATA[28 +: 28] = 28'h0B1000B; CH_DATA[56 +: 28] = 28'h0B2000B; tick();
    CH_WRITE = '0;
    sb.push_back(32'h10B1000A); sb.push_back(32'h20B2000A);
    sb.push_back(32'h10B1000B); sb.push_back(32'h20B2000B);
    drain();

    // Overflow on ch0 behind a stalled output word.
    OUT_READ = 1'b0;
    sb.push_back(32'h10111111);
    wr1(1, 28'h0111111);
    tick();
    for (int i = 0; i < 18; i++) begin
      if (i == 15) chk("ovf_ready_before", 64'(CH_READY[0]), 1);
      if (i == 16) chk("ovf_ready_full", 64'(CH_READY[0]), 0);
      CH_WRITE[0] = 1'b1;
      CH_DATA[27:0] = 28'h000C000 + 28'(i);
      if (i < 16) sb.push_back({4'h0, 28'h000C000 + 28'(i)});
      tick();
    end
    CH_WRITE = '0;
    chk("ovf_lost0", LOST_CNT[7:0], 2);
    chk("ovf_ready_after", 64'(CH_READY[0]), 0);
`ifdef CHIP_MERGER_OVF_MARKER_EN
    sb.push_back(32'h80000002);
`endif
    drain();
    chk("ovf_ready_drained", 64'(CH_READY[0]), 1);
    sb.push_back(32'h00C0FFEE);
    wr1(0, 28'h0C0FFEE);
    drain();

    // Saturation of ch1 drop counter.
    OUT_READ = 1'b0;
    sb.push_back(32'h000D0D0D);
    wr1(0, 28'h00D0D0D);
    tick();
    for (int i = 0; i < 316; i++) begin
      CH_WRITE[1] = 1'b1;
      CH_DATA[55:28] = 28'h000E000 + 28'(i);
      if (i < 16) sb.push_back({4'h1, 28'h000E000 + 28'(i)});
      tick();
    end
    CH_WRITE = '0;
    chk("sat_lost1", LOST_CNT[15:8], 255);
    chk("sat_lost0_keep", LOST_CNT[7:0], 2);
`ifdef CHIP_MERGER_OVF_MARKER_EN
    sb.push_back(32'h9000012C);
`endif
    drain();

    // Disable ch3 (and ch1) while ch3 holds 5 words.
    OUT_READ = 1'b0;
    sb.push_back(32'h00F0F0F0);
    wr1(0, 28'h0F0F0F0);
    tick();
    for (int i = 0; i < 5; i++) wr1(3, 28'h0000330 + 28'(i));
    CH_EN = 4'b0101;
    CH_WRITE = 4'b1000; CH_DATA[111:84] = 28'h0DEAD00;
    tick();
    CH_WRITE = '0;
    chk("dis_ready", CH_READY, 4'b0101);
    chk("dis_lost3", LOST_CNT[31:24], 0);
    chk("dis_lost1_keep", LOST_CNT[15:8], 255);
    CH_EN = '1;
    tick();
    chk("reen_ready", CH_READY, 4'hF);
    drain();
    sb.push_back(32'h30000777);
    wr1(3, 28'h0000777);
    drain();

    // CLEAR mid-burst: nothing survives, counters zeroed.
    OUT_READ = 1'b0;
    wr1(0, 28'h0123456);
    tick();
    CH_WRITE = 4'b0100; CH_DATA[83:56] = 28'h0222222;
    tick(); tick();
    chk("pre_clr_lost", LOST_CNT, 32'h0000FF02);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0; CH_WRITE = '0;
    chk("clr_valid", 64'(OUT_VALID), 0);
    chk("clr_data", OUT_DATA, 0);
    chk("clr_lost", LOST_CNT, 0);
    chk("clr_ready", CH_READY, 0);
    tick();
    chk("clr_ready_after", CH_READY, 4'hF);
    OUT_READ = 1'b1;
    repeat (4) tick();
    chk("clr_no_out", 64'(OUT_VALID), 0);
    chk("clr_sb_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
